// File: rtl/calpoc_button_conditioner_if.sv
// calpoc_button_conditioner_if: raw button levels in, conditioned press pulses and debounced levels out
interface calpoc_button_conditioner_if;
  logic [5:0] RawButtons;
  logic       ButtonFor1;
  logic       ButtonFor0;
  logic       ButtonForOR;
  logic       ButtonForXOR;
  logic       ButtonForEquals;
  logic       ButtonForClear;
  logic [5:0] ButtonHeld;
  modport master (
    output RawButtons,
    input  ButtonFor1, ButtonFor0, ButtonForOR, ButtonForXOR, ButtonForEquals, ButtonForClear, ButtonHeld
  );
  modport slave (
    input  RawButtons,
    output ButtonFor1, ButtonFor0, ButtonForOR, ButtonForXOR, ButtonForEquals, ButtonForClear, ButtonHeld
  );
endinterface

// File: rtl/calpoc_button_conditioner.sv
// calpoc_button_conditioner: per-button sync, debounce and press-pulse generation for the CalPOC calculator
// Define CALPOC_BTN_ONEHOT_EN to add a registered one-hot arbiter (Clear > Equals > OR > XOR > 0 > 1).
module calpoc_button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input logic CLK,
  input logic RST,
  calpoc_button_conditioner_if.slave btn
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic [5:0] r_sync1, r_sync2, r_stable, r_pulse, w_hit, w_out;
  logic [CNT_W-1:0] r_cnt [6];
  for (genvar i = 0; i < 6; i++) begin : g_hit
    assign w_hit[i] = (r_sync2[i] != r_stable[i]) && (r_cnt[i] == CNT_MAX);
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_stable <= '0;
      r_pulse  <= '0;
      for (int i = 0; i < 6; i++) r_cnt[i] <= '0;
    end else begin
      r_sync1  <= btn.RawButtons;
      r_sync2  <= r_sync1;
      r_stable <= r_stable ^ w_hit;
      r_pulse  <= w_hit & r_sync2;
      for (int i = 0; i < 6; i++)
        r_cnt[i] <= (r_sync2[i] != r_stable[i]) && !w_hit[i] ? r_cnt[i] + 1'b1 : '0;
    end
  end
`ifdef CALPOC_BTN_ONEHOT_EN
  logic [5:0] w_sel, r_arb;
  // OR outranks XOR to match the calculator FSM's input priority
  always_comb
    w_sel = r_pulse[5] ? 6'b100000 :
            r_pulse[4] ? 6'b010000 :
            r_pulse[2] ? 6'b000100 :
            r_pulse[3] ? 6'b001000 :
            r_pulse[1] ? 6'b000010 :
            r_pulse[0] ? 6'b000001 : 6'b000000;
  always_ff @(posedge CLK) r_arb <= RST ? '0 : w_sel;
  assign w_out = r_arb;
`else
  assign w_out = r_pulse;
`endif
  assign btn.ButtonFor1      = w_out[0];
  assign btn.ButtonFor0      = w_out[1];
  assign btn.ButtonForOR     = w_out[2];
  assign btn.ButtonForXOR    = w_out[3];
  assign btn.ButtonForEquals = w_out[4];
  assign btn.ButtonForClear  = w_out[5];
  assign btn.ButtonHeld      = r_stable;
endmodule

// File: tb/tb_calpoc_button_conditioner.sv
// tb_calpoc_button_conditioner: directed vectors with hand-computed pulse/held timing per button
module tb_calpoc_button_conditioner;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  calpoc_button_conditioner_if bif ();
  calpoc_button_conditioner dut (.CLK(clk), .RST(rst), .btn(bif));
  wire [5:0] pv = {bif.ButtonForClear, bif.ButtonForEquals, bif.ButtonForXOR,
                   bif.ButtonForOR, bif.ButtonFor0, bif.ButtonFor1};
`ifdef CALPOC_BTN_ONEHOT_EN
  localparam int ARB = 1;
`else
  localparam int ARB = 0;
`endif
  int total = 0;
  int bad = 0;
  int t;
  int np [6];
  int fp [6];
  int lp [6];
  int hr [6];
  int hf [6];
  logic [5:0] hprev;
  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask
  task automatic clr();
    t = 0;
    for (int i = 0; i < 6; i++) begin
      np[i] = 0; fp[i] = -1; lp[i] = -1; hr[i] = -1; hf[i] = -1;
    end
    hprev = bif.ButtonHeld;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    t++;
    for (int i = 0; i < 6; i++) begin
      if (pv[i]) begin
        np[i]++;
        if (fp[i] < 0) fp[i] = t;
        lp[i] = t;
      end
      if (bif.ButtonHeld[i] && !hprev[i] && hr[i] < 0) hr[i] = t;
      if (!bif.ButtonHeld[i] && hprev[i] && hf[i] < 0) hf[i] = t;
    end
    hprev = bif.ButtonHeld;
  endtask
  task automatic watch(input int n);
    repeat (n) tick();
  endtask
  task automatic do_reset();
    rst = 1'b1;
    bif.RawButtons = '0;
    watch(2);
    rst = 1'b0;
    clr();
  endtask
  initial begin
    bif.RawButtons = 6'h3F;
    rst = 1'b1;
    clr();
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("rst_out%0d", k), {26'd0, pv | bif.ButtonHeld}, 0);
    end
    rst = 1'b0;
    clr();
    watch(20);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("rst_np%0d", i), np[i], (ARB != 0 && i != 5) ? 0 : 1);
      chk($sformatf("rst_fp%0d", i), fp[i], (ARB != 0 && i != 5) ? -1 : 6 + ARB);
      chk($sformatf("rst_hr%0d", i), hr[i], 6);
    end
    do_reset();
    bif.RawButtons = 6'b000001;
    watch(20);
    chk("press_np", np[0], 1);
    chk("press_fp", fp[0], 6 + ARB);
    chk("press_hr", hr[0], 6);
    chk("press_held", bif.ButtonHeld, 6'b000001);
    do_reset();
    bif.RawButtons = 6'b000100;
    watch(3);
    bif.RawButtons = 6'b000000;
    watch(15);
    chk("glitch_np", np[2], 0);
    chk("glitch_hr", hr[2], -1);
    do_reset();
    bif.RawButtons = 6'b000100;
    watch(3);
    bif.RawButtons = 6'b000000;
    watch(1);
    bif.RawButtons = 6'b000100;
    watch(3);
    bif.RawButtons = 6'b000000;
    watch(15);
    chk("regl_np", np[2], 0);
    chk("regl_hr", hr[2], -1);
    do_reset();
    bif.RawButtons = 6'b000100;
    watch(4);
    bif.RawButtons = 6'b000000;
    watch(15);
    chk("edge4_np", np[2], 1);
    chk("edge4_fp", fp[2], 6 + ARB);
    chk("edge4_hf", hf[2], 10);
    do_reset();
    for (int k = 0; k < 5; k++) begin
      bif.RawButtons = (k % 2 == 0) ? 6'b010000 : 6'b000000;
      tick();
    end
    bif.RawButtons = 6'b010000;
    watch(25);
    chk("bounce_np", np[4], 1);
    chk("bounce_fp", fp[4], 10 + ARB);
    do_reset();
    bif.RawButtons = 6'b001000;
    watch(10);
    bif.RawButtons = 6'b000000;
    watch(10);
    bif.RawButtons = 6'b001000;
    watch(15);
    chk("repress_np", np[3], 2);
    chk("repress_fp", fp[3], 6 + ARB);
    chk("repress_lp", lp[3], 26 + ARB);
    chk("repress_hf", hf[3], 16);
    do_reset();
    bif.RawButtons = 6'b100010;
    watch(15);
    chk("simul_np0", np[1], 1 - ARB);
    chk("simul_npc", np[5], 1);
    chk("simul_fpc", fp[5], 6 + ARB);
    chk("simul_held", bif.ButtonHeld, 6'b100010);
    do_reset();
    bif.RawButtons = 6'b000001;
    watch(4);
    rst = 1'b1;
    tick();
    chk("midrst_out", {26'd0, pv | bif.ButtonHeld}, 0);
    rst = 1'b0;
    clr();
    watch(15);
    chk("midrst_np", np[0], 1);
    chk("midrst_fp", fp[0], 6 + ARB);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
